cond_exec_stage: RTL and testbench

- Decode→execute boundary of the pipelined core: captures decoder control outputs into the ID/EX control register and owns the architectural NZCV flag register.
- Evaluates the 4-bit ARM condition field against the stored flags.
- Drives the condition-gated write/branch enables consumed by the execute, memory and fetch stages.
- Sits directly downstream of the decoder, alongside the ALU, whose flags it captures.

---
 rtl/cond_exec_if.sv | 40 ++++
 rtl/cond_exec_stage.sv | 105 ++++++++++
 tb/tb_cond_exec_stage.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cond_exec_if.sv
// Decode-to-execute control bundle: decoder fields, hazard controls,
// ALU flags in, and the registered/condition-gated execute controls out.
interface cond_exec_if;
    logic       StallE;
    logic       FlushE;
    logic       PCSrcD;
    logic       RegWriteD;
    logic       MemWriteD;
    logic       MemtoRegD;
    logic       BranchD;
    logic       ALUSrcD;
    logic [2:0] ALUControlD;
    logic [1:0] FlagWriteD;
    logic [3:0] CondD;
    logic [3:0] ALUFlags;

    logic [2:0] ALUControlE;
    logic       ALUSrcE;
    logic       MemtoRegE;
    logic       RegWriteE;
    logic       MemWriteE;
    logic       PCSrcE;
    logic       BranchTakenE;
    logic       CondExE;
    logic [3:0] FlagsE;

    modport master (
        output StallE, FlushE, PCSrcD, RegWriteD, MemWriteD, MemtoRegD,
               BranchD, ALUSrcD, ALUControlD, FlagWriteD, CondD, ALUFlags,
        input  ALUControlE, ALUSrcE, MemtoRegE, RegWriteE, MemWriteE,
               PCSrcE, BranchTakenE, CondExE, FlagsE
    );

    modport slave (
        input  StallE, FlushE, PCSrcD, RegWriteD, MemWriteD, MemtoRegD,
               BranchD, ALUSrcD, ALUControlD, FlagWriteD, CondD, ALUFlags,
        output ALUControlE, ALUSrcE, MemtoRegE, RegWriteE, MemWriteE,
               PCSrcE, BranchTakenE, CondExE, FlagsE
    );
endinterface

// File: rtl/cond_exec_stage.sv
// ID/EX control register, architectural NZCV flags and ARM condition
// evaluation. Every output depends only on registers, never on D inputs.
module cond_exec_stage #(
    parameter bit         NV_EXECUTES = 1'b0,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input logic        clk,
    input logic        reset,
    cond_exec_if.slave bus
);

    logic       pcsrc_r;
    logic       regwrite_r;
    logic       memwrite_r;
    logic       memtoreg_r;
    logic       branch_r;
    logic       alusrc_r;
    logic [2:0] alu_ctrl_r;
    logic [1:0] flag_write_r;
    logic [3:0] cond_r;
    logic [3:0] flags_r;
    logic       cond_ex;
    logic       n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = flags_r;

    // ID/EX control register: flush (bubble) beats stall (hold) beats capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcsrc_r      <= 1'b0;
            regwrite_r   <= 1'b0;
            memwrite_r   <= 1'b0;
            memtoreg_r   <= 1'b0;
            branch_r     <= 1'b0;
            alusrc_r     <= 1'b0;
            alu_ctrl_r   <= 3'b000;
            flag_write_r <= 2'b00;
            cond_r       <= 4'b1110;
        end else if (bus.FlushE) begin
            pcsrc_r      <= 1'b0;
            regwrite_r   <= 1'b0;
            memwrite_r   <= 1'b0;
            memtoreg_r   <= 1'b0;
            branch_r     <= 1'b0;
            alusrc_r     <= 1'b0;
            alu_ctrl_r   <= 3'b000;
            flag_write_r <= 2'b00;
            cond_r       <= 4'b1110;
        end else if (!bus.StallE) begin
            pcsrc_r      <= bus.PCSrcD;
            regwrite_r   <= bus.RegWriteD;
            memwrite_r   <= bus.MemWriteD;
            memtoreg_r   <= bus.MemtoRegD;
            branch_r     <= bus.BranchD;
            alusrc_r     <= bus.ALUSrcD;
            alu_ctrl_r   <= bus.ALUControlD;
            flag_write_r <= bus.FlagWriteD;
            cond_r       <= bus.CondD;
        end
    end

    // Condition check of the instruction in E against flags from older instructions
    always_comb begin
        cond_ex = 1'b0;
        case (cond_r)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = !z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = !c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = !n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = !v_f;
            4'b1000: cond_ex = c_f & !z_f;
            4'b1001: cond_ex = !c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = !z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = NV_EXECUTES;
        endcase
    end

    // Flags commit only on the edge the instruction leaves E; a flush still lets it leave
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_r <= RESET_FLAGS;
        end else if (!bus.StallE && cond_ex) begin
            if (flag_write_r[1]) flags_r[3:2] <= bus.ALUFlags[3:2];
            if (flag_write_r[0]) flags_r[1:0] <= bus.ALUFlags[1:0];
        end
    end

    assign bus.ALUControlE  = alu_ctrl_r;
    assign bus.ALUSrcE      = alusrc_r;
    assign bus.MemtoRegE    = memtoreg_r;
    assign bus.RegWriteE    = regwrite_r & cond_ex;
    assign bus.MemWriteE    = memwrite_r & cond_ex;
    assign bus.PCSrcE       = (pcsrc_r | branch_r) & cond_ex;
    assign bus.BranchTakenE = branch_r & cond_ex;
    assign bus.CondExE      = cond_ex;
    assign bus.FlagsE       = flags_r;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Directed bench for cond_exec_stage; two instances differ only in NV_EXECUTES.
module tb_cond_exec_stage;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    cond_exec_if b0();
    cond_exec_if b1();

    cond_exec_stage #(.NV_EXECUTES(1'b0), .RESET_FLAGS(4'b0000)) dut0 (
        .clk(clk), .reset(reset), .bus(b0.slave));
    cond_exec_stage #(.NV_EXECUTES(1'b1), .RESET_FLAGS(4'b0000)) dut1 (
        .clk(clk), .reset(reset), .bus(b1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic pcs, input logic rw, input logic mw, input logic m2r,
                         input logic br, input logic asrc, input logic [2:0] alu,
                         input logic [1:0] fw, input logic [3:0] cond);
        b0.PCSrcD = pcs;  b0.RegWriteD = rw; b0.MemWriteD = mw; b0.MemtoRegD = m2r;
        b0.BranchD = br;  b0.ALUSrcD = asrc; b0.ALUControlD = alu; b0.FlagWriteD = fw;
        b0.CondD = cond;
        b1.PCSrcD = pcs;  b1.RegWriteD = rw; b1.MemWriteD = mw; b1.MemtoRegD = m2r;
        b1.BranchD = br;  b1.ALUSrcD = asrc; b1.ALUControlD = alu; b1.FlagWriteD = fw;
        b1.CondD = cond;
    endtask

    task automatic set_ctl(input logic stall, input logic flush, input logic [3:0] flags);
        b0.StallE = stall; b0.FlushE = flush; b0.ALUFlags = flags;
        b1.StallE = stall; b1.FlushE = flush; b1.ALUFlags = flags;
    endtask

    task automatic nop();
        set_d(0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 4'b1110);
    endtask

    task automatic adds();
        set_d(0, 1, 0, 0, 0, 0, 3'b000, 2'b11, 4'b1110);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f, input logic nv);
        logic n, z, cc, v;
        {n, z, cc, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cc;
            4'd3:  return !cc;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cc && !z;
            4'd9:  return !cc || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return nv;
        endcase
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        nop();
        set_ctl(0, 0, 4'b0000);
        #7;
        chk("rst_flags", b0.FlagsE, 4'h0);
        chk("rst_regwrite", {3'b0, b0.RegWriteE}, 4'h0);
        chk("rst_memwrite", {3'b0, b0.MemWriteE}, 4'h0);
        chk("rst_pcsrc", {3'b0, b0.PCSrcE}, 4'h0);
        chk("rst_branch", {3'b0, b0.BranchTakenE}, 4'h0);
        chk("rst_aluctrl", {1'b0, b0.ALUControlE}, 4'h0);
        chk("rst_condex", {3'b0, b0.CondExE}, 4'h1);
        #3 reset = 1'b0;

        // SUBS then BEQ
        set_d(0, 1, 0, 0, 0, 0, 3'b010, 2'b11, 4'b1110);
        step();
        chk("subs_aluctrl", {1'b0, b0.ALUControlE}, 4'h2);
        chk("subs_regwrite", {3'b0, b0.RegWriteE}, 4'h1);
        chk("subs_flags_before", b0.FlagsE, 4'h0);
        set_ctl(0, 0, 4'b0110);
        set_d(0, 0, 0, 0, 1, 0, 3'b000, 2'b00, 4'b0000);
        step();
        chk("subs_flags_after", b0.FlagsE, 4'h6);
        chk("beq_taken", {3'b0, b0.BranchTakenE}, 4'h1);
        chk("beq_pcsrc", {3'b0, b0.PCSrcE}, 4'h1);

        // clear flags, BNE taken, STR EQ fails, ADDS EQ fails
        adds();
        set_ctl(0, 0, 4'b0000);
        step();
        set_d(0, 0, 0, 0, 1, 0, 3'b000, 2'b00, 4'b0001);
        step();
        chk("clr_flags", b0.FlagsE, 4'h0);
        chk("bne_taken", {3'b0, b0.BranchTakenE}, 4'h1);
        set_d(0, 0, 1, 0, 0, 1, 3'b000, 2'b00, 4'b0000);
        step();
        chk("streq_memwrite", {3'b0, b0.MemWriteE}, 4'h0);
        chk("streq_condex", {3'b0, b0.CondExE}, 4'h0);
        chk("streq_alusrc", {3'b0, b0.ALUSrcE}, 4'h1);
        set_d(0, 1, 0, 0, 0, 0, 3'b000, 2'b11, 4'b0000);
        step();
        chk("addseq_regwrite", {3'b0, b0.RegWriteE}, 4'h0);
        set_ctl(0, 0, 4'b1000);
        nop();
        step();
        chk("addseq_flags", b0.FlagsE, 4'h0);

        // partial NZ update
        adds();
        step();
        set_ctl(0, 0, 4'b0011);
        set_d(0, 1, 0, 0, 0, 0, 3'b000, 2'b10, 4'b1110);
        step();
        chk("part_flags_pre", b0.FlagsE, 4'h3);
        set_ctl(0, 0, 4'b1100);
        nop();
        step();
        chk("part_flags", b0.FlagsE, 4'hF);

        // stall holds flag write until release
        adds();
        step();
        set_ctl(1, 0, 4'b0101);
        nop();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_flags", b0.FlagsE, 4'hF);
            chk("stall_regwrite", {3'b0, b0.RegWriteE}, 4'h1);
        end
        set_ctl(0, 0, 4'b0101);
        step();
        chk("release_flags", b0.FlagsE, 4'h5);
        chk("release_regwrite", {3'b0, b0.RegWriteE}, 4'h0);
        set_ctl(0, 0, 4'b1010);
        step();
        chk("once_flags", b0.FlagsE, 4'h5);

        // flush beats stall
        set_d(0, 1, 0, 0, 0, 0, 3'b011, 2'b00, 4'b1110);
        step();
        chk("add_regwrite", {3'b0, b0.RegWriteE}, 4'h1);
        chk("add_aluctrl", {1'b0, b0.ALUControlE}, 4'h3);
        set_ctl(1, 1, 4'b1010);
        step();
        chk("fs_regwrite", {3'b0, b0.RegWriteE}, 4'h0);
        chk("fs_aluctrl", {1'b0, b0.ALUControlE}, 4'h0);
        chk("fs_condex", {3'b0, b0.CondExE}, 4'h1);
        chk("fs_flags", b0.FlagsE, 4'h5);

        // flush with flag-setter in E still commits its flags
        set_ctl(0, 0, 4'b1010);
        adds();
        step();
        set_ctl(0, 1, 4'b1001);
        nop();
        step();
        chk("flush_setter_flags", b0.FlagsE, 4'h9);
        chk("flush_setter_regwrite", {3'b0, b0.RegWriteE}, 4'h0);
        set_ctl(0, 0, 4'b1001);

        // asynchronous reset with ADDS in E
        adds();
        step();
        chk("pre_rst_regwrite", {3'b0, b0.RegWriteE}, 4'h1);
        set_ctl(0, 0, 4'b1010);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_flags", b0.FlagsE, 4'h0);
        chk("async_rst_regwrite", {3'b0, b0.RegWriteE}, 4'h0);
        chk("async_rst_aluctrl", {1'b0, b0.ALUControlE}, 4'h0);
        #1 reset = 1'b0;
        nop();
        step();
        chk("post_rst_flags", b0.FlagsE, 4'h0);

        // condition sweep over every flag value
        for (int f = 0; f < 16; f++) begin
            adds();
            set_ctl(0, 0, 4'(f));
            step();
            nop();
            step();
            chk("sweep_flags", b0.FlagsE, 4'(f));
            for (int c = 0; c < 16; c++) begin
                set_d(0, 1, 0, 0, 0, 0, 3'b000, 2'b00, 4'(c));
                step();
                chk($sformatf("sweep_nv0_c%0d_f%0d", c, f), {3'b0, b0.RegWriteE},
                    {3'b0, cond_model(4'(c), 4'(f), 1'b0)});
                chk($sformatf("sweep_nv1_c%0d_f%0d", c, f), {3'b0, b1.RegWriteE},
                    {3'b0, cond_model(4'(c), 4'(f), 1'b1)});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
